// File: rtl/phase_sequencer_if.sv
// Signal bundle between the phase sequencer and its host datapath/controller.
// Carries the STEP line only when STEP_MODE_EN is defined.
interface phase_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic             halt_cmd;
    logic             mem_access;
    logic             mem_ready;
`ifdef STEP_MODE_EN
    logic             step;
`endif
    logic [4:0]       phase;
    logic             ir_load;
    logic             pc_inc;
    logic             mem_en;
    logic             reg_we_en;
    logic             running;
    logic             halted;
    logic             err;
    logic [CNT_W-1:0] instr_cnt;

`ifdef STEP_MODE_EN
    modport master (
        output start, halt_cmd, mem_access, mem_ready, step,
        input  phase, ir_load, pc_inc, mem_en, reg_we_en, running, halted, err, instr_cnt
    );
    modport slave (
        input  start, halt_cmd, mem_access, mem_ready, step,
        output phase, ir_load, pc_inc, mem_en, reg_we_en, running, halted, err, instr_cnt
    );
`else
    modport master (
        output start, halt_cmd, mem_access, mem_ready,
        input  phase, ir_load, pc_inc, mem_en, reg_we_en, running, halted, err, instr_cnt
    );
    modport slave (
        input  start, halt_cmd, mem_access, mem_ready,
        output phase, ir_load, pc_inc, mem_en, reg_we_en, running, halted, err, instr_cnt
    );
`endif
endinterface

// File: rtl/phase_sequencer.sv
// Five-phase instruction sequencer (IDLE, P1 fetch .. P5 writeback, HALT; PAUSE with STEP_MODE_EN).
// Moore outputs; P4 waits for data memory up to MEM_WAIT_MAX wait cycles, then halts with ERR.
module phase_sequencer #(
    parameter int CNT_W        = 16,
    parameter int MEM_WAIT_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,
    phase_sequencer_if.slave  io_bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_P1    = 3'd1,
        S_P2    = 3'd2,
        S_P3    = 3'd3,
        S_P4    = 3'd4,
        S_P5    = 3'd5,
`ifdef STEP_MODE_EN
        S_HALT  = 3'd6,
        S_PAUSE = 3'd7
`else
        S_HALT  = 3'd6
`endif
    } state_t;

    localparam logic [7:0] WAIT_LIMIT = 8'(MEM_WAIT_MAX);

    state_t           r_state;
    state_t           w_next;
    logic             r_mem_flag;
    logic [7:0]       r_wait;
    logic             r_err;
    logic [CNT_W-1:0] r_instr_cnt;
    logic             w_timeout;

    // Ready in the last allowed wait cycle still completes the access.
    assign w_timeout = r_mem_flag && !io_bus.mem_ready && (r_wait == WAIT_LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (io_bus.start) w_next = S_P1;
            S_P1:    w_next = S_P2;
            S_P2:    w_next = io_bus.halt_cmd ? S_HALT : S_P3;
            S_P3:    w_next = S_P4;
            S_P4: begin
                if (!r_mem_flag || io_bus.mem_ready) w_next = S_P5;
                else if (w_timeout)                  w_next = S_HALT;
            end
`ifdef STEP_MODE_EN
            S_P5:    w_next = S_PAUSE;
            S_PAUSE: if (io_bus.step) w_next = S_P1;
`else
            S_P5:    w_next = S_P1;
`endif
            S_HALT:  if (io_bus.start) w_next = S_P1;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        io_bus.phase     = 5'b00000;
        io_bus.ir_load   = 1'b0;
        io_bus.pc_inc    = 1'b0;
        io_bus.mem_en    = 1'b0;
        io_bus.reg_we_en = 1'b0;
        io_bus.running   = 1'b0;
        io_bus.halted    = 1'b0;
        case (r_state)
            S_P1: begin
                io_bus.phase   = 5'b00001;
                io_bus.ir_load = 1'b1;
                io_bus.pc_inc  = 1'b1;
                io_bus.running = 1'b1;
            end
            S_P2: begin
                io_bus.phase   = 5'b00010;
                io_bus.running = 1'b1;
            end
            S_P3: begin
                io_bus.phase   = 5'b00100;
                io_bus.running = 1'b1;
            end
            S_P4: begin
                io_bus.phase   = 5'b01000;
                io_bus.mem_en  = r_mem_flag;
                io_bus.running = 1'b1;
            end
            S_P5: begin
                io_bus.phase     = 5'b10000;
                io_bus.reg_we_en = 1'b1;
                io_bus.running   = 1'b1;
            end
`ifdef STEP_MODE_EN
            S_PAUSE: io_bus.running = 1'b1;
`endif
            S_HALT:  io_bus.halted = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_flag  <= 1'b0;
            r_wait      <= 8'd0;
            r_err       <= 1'b0;
            r_instr_cnt <= '0;
        end else begin
            if (r_state == S_P2) r_mem_flag <= io_bus.mem_access;

            if (r_state != S_P4)                        r_wait <= 8'd0;
            else if (r_mem_flag && !io_bus.mem_ready)   r_wait <= r_wait + 8'd1;

            if (r_state == S_P4 && w_timeout)            r_err <= 1'b1;
            else if (r_state == S_HALT && io_bus.start)  r_err <= 1'b0;

            if (r_state == S_P5 && r_instr_cnt != {CNT_W{1'b1}})
                r_instr_cnt <= r_instr_cnt + 1'b1;
        end
    end

    assign io_bus.err       = r_err;
    assign io_bus.instr_cnt = r_instr_cnt;

endmodule

// File: tb/tb_phase_sequencer.sv
// Randomized instruction-level bench for phase_sequencer with a retire/halt scoreboard.
module tb_phase_sequencer;
    localparam int CNT_W   = 4;
    localparam int MAX     = 8;
    localparam int N_INSTR = 60;
    localparam int CNT_TOP = (1 << CNT_W) - 1;

    typedef struct {
        bit halt;
        bit err;
        int len;
        int memc;
        int cnt_before;
        int cnt_after;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    phase_sequencer_if #(.CNT_W(CNT_W)) sq ();

    phase_sequencer #(.CNT_W(CNT_W), .MEM_WAIT_MAX(MAX)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (sq.slave)
    );

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: tracks cycles of the current instruction, compares on retire (P5) and on HALT entry
    bit   mon_en = 1'b0;
    bit   prev_halted = 1'b0;
    bit   pend = 1'b0;
    int   pend_cnt = 0;
    int   len = 0;
    int   memc = 0;
    int   strb = 0;
    exp_t me;

    always @(negedge clk) begin
        if (mon_en) begin
            if (sq.phase == 5'b00001) begin
                len  = 1;
                memc = sq.mem_en ? 1 : 0;
                strb = (sq.ir_load ? 1 : 0) + (sq.pc_inc ? 1 : 0);
                if (pend) begin
                    check("cnt_next_p1", int'(sq.instr_cnt), pend_cnt);
                    check("err_next_p1", int'(sq.err), 0);
                    pend = 1'b0;
                end
            end else if (sq.phase != 5'b00000) begin
                len++;
                memc += sq.mem_en ? 1 : 0;
                strb += (sq.ir_load ? 1 : 0) + (sq.pc_inc ? 1 : 0);
            end

            if (sq.reg_we_en) begin
                if (sb_q.size() == 0) check("sb_underflow_retire", 1, 0);
                else begin
                    me = sb_q.pop_front();
                    check("retire_not_halt", 0, int'(me.halt));
                    check("retire_len", len, me.len);
                    check("retire_mem_en_cycles", memc, me.memc);
                    check("retire_cnt_in_p5", int'(sq.instr_cnt), me.cnt_before);
                    check("retire_err", int'(sq.err), 0);
                    check("retire_strobes", strb, 2);
                    pend = 1'b1;
                    pend_cnt = me.cnt_after;
                end
            end

            if (sq.halted && !prev_halted) begin
                if (sb_q.size() == 0) check("sb_underflow_halt", 1, 0);
                else begin
                    me = sb_q.pop_front();
                    check("halt_expected", 1, int'(me.halt));
                    check("halt_len", len, me.len);
                    check("halt_mem_en_cycles", memc, me.memc);
                    check("halt_err", int'(sq.err), int'(me.err));
                    check("halt_cnt_kept", int'(sq.instr_cnt), me.cnt_before);
                    check("halt_running", int'(sq.running), 0);
                    check("halt_phase", int'(sq.phase), 0);
                    pend = 1'b1;
                    pend_cnt = me.cnt_after;
                end
            end
        end
        prev_halted = sq.halted;
    end

    int   cnt_m = 0;
    bit   abort = 1'b0;
    bit   done;
    bit   h, m;
    int   w, k;
    exp_t de;

    initial begin
        sq.start = 1'b0; sq.halt_cmd = 1'b0; sq.mem_access = 1'b0; sq.mem_ready = 1'b0;
`ifdef STEP_MODE_EN
        sq.step = 1'b0;
`endif
        #3;
        check("rst_phase", int'(sq.phase), 0);
        check("rst_running", int'(sq.running), 0);
        check("rst_halted", int'(sq.halted), 0);
        check("rst_err", int'(sq.err), 0);
        check("rst_cnt", int'(sq.instr_cnt), 0);
        check("rst_strobes", int'({sq.ir_load, sq.pc_inc, sq.mem_en, sq.reg_we_en}), 0);
        @(negedge clk);
        rst = 1'b0;
        sq.mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_without_start", int'(sq.phase), 0);
        sq.mem_ready = 1'b0;
        sq.start = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        sq.start = 1'b0;

        for (int n = 0; n < N_INSTR && !abort; n++) begin
            if (sq.phase != 5'b00001) begin
                check("instr_starts_in_p1", int'(sq.phase), 1);
                abort = 1'b1;
                break;
            end
            case (n)
                0: begin h = 0; m = 0; w = 0;       end
                1: begin h = 0; m = 1; w = 2;       end
                2: begin h = 0; m = 1; w = MAX + 1; end
                3: begin h = 1; m = 1; w = 0;       end
                4: begin h = 0; m = 1; w = MAX;     end
                5: begin h = 0; m = 1; w = 0;       end
                default: begin
                    h = ($urandom_range(0, 7) == 0);
                    m = $urandom_range(0, 1) != 0;
                    w = $urandom_range(0, MAX + 1);
                end
            endcase
            de.cnt_before = cnt_m;
            de.err = 1'b0;
            if (h) begin
                de.halt = 1'b1; de.len = 2; de.memc = 0;
            end else if (m && w > MAX) begin
                de.halt = 1'b1; de.err = 1'b1; de.len = 3 + MAX + 1; de.memc = MAX + 1;
            end else begin
                de.halt = 1'b0;
                de.len  = m ? 5 + w : 5;
                de.memc = m ? w + 1 : 0;
                cnt_m   = (cnt_m < CNT_TOP) ? cnt_m + 1 : CNT_TOP;
            end
            de.cnt_after = cnt_m;
            sb_q.push_back(de);

            sq.halt_cmd = h;
            sq.mem_access = m;
            k = 0;
            done = 1'b0;
            for (int c = 0; c < 40 && !done; c++) begin
                @(negedge clk);
                if (sq.phase == 5'b01000) begin
                    sq.mem_ready = m && (k == w);
                    sq.start = $urandom_range(0, 1) != 0;
                    k++;
                end else if (sq.reg_we_en) begin
                    sq.mem_ready = 1'b0;
                    sq.start = 1'b0;
                    done = 1'b1;
`ifdef STEP_MODE_EN
                    @(negedge clk);
                    check("pause_running", int'(sq.running), 1);
                    check("pause_phase", int'(sq.phase), 0);
                    sq.step = 1'b1;
                    @(negedge clk);
                    sq.step = 1'b0;
`else
                    @(negedge clk);
`endif
                end else if (sq.halted) begin
                    sq.mem_ready = 1'b0;
                    sq.start = 1'b1;
                    done = 1'b1;
                    @(negedge clk);
                    sq.start = 1'b0;
                end else begin
                    sq.mem_ready = $urandom_range(0, 1) != 0;
                    sq.start = $urandom_range(0, 1) != 0;
                end
            end
            if (!done) begin
                check("instr_cycle_budget", 0, 1);
                abort = 1'b1;
            end
        end

        for (int c = 0; c < 20 && sb_q.size() != 0; c++) @(negedge clk);
        check("sb_drained", sb_q.size(), 0);

        // Asynchronous reset in the middle of a memory wait
        mon_en = 1'b0;
        sq.start = 1'b0; sq.halt_cmd = 1'b0; sq.mem_access = 1'b1; sq.mem_ready = 1'b0;
        for (int c = 0; c < 20 && !sq.mem_en; c++) @(negedge clk);
        check("reached_p4_mem_en", int'(sq.mem_en), 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_phase", int'(sq.phase), 0);
        check("async_rst_strobes", int'({sq.ir_load, sq.pc_inc, sq.mem_en, sq.reg_we_en}), 0);
        check("async_rst_status", int'({sq.running, sq.halted, sq.err}), 0);
        check("async_rst_cnt", int'(sq.instr_cnt), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("post_rst_idle", int'(sq.phase), 0);
        check("post_rst_running", int'(sq.running), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/phase_sequencer.md
PHASE_SEQUENCER -- requirements
Module: phase_sequencer

Interface
REQ-001 Parameter CNT_W, default 16, width of the retired-instruction counter.
REQ-002 Parameter MEM_WAIT_MAX, default 8, maximum P4 wait cycles before timeout (range 1..255).
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 START  input  1  begin or resume execution; level sampled on clk.
REQ-006 HALT_CMD  input  1  decoded halt instruction; sampled only in P2.
REQ-007 MEM_ACCESS  input  1  decoded instruction uses data memory; sampled only in P2.
REQ-008 MEM_READY  input  1  data memory completes the access; used only in P4.
REQ-009 STEP  input  1  single-step advance; present only when STEP_MODE_EN is defined.
REQ-010 PHASE  output  5  one-hot phase; bit0=P1 fetch … bit4=P5 writeback.
REQ-011 IR_LOAD  output  1  instruction-register load strobe.
REQ-012 PC_INC  output  1  program-counter increment strobe.
REQ-013 MEM_EN  output  1  data-memory access enable.
REQ-014 REG_WE_EN  output  1  qualifier ANDed externally with the decoder writeEnable.
REQ-015 RUNNING  output  1  sequencer is in P1..P5 or PAUSE.
REQ-016 HALTED  output  1  sequencer is in HALT.
REQ-017 ERR  output  1  memory timeout occurred; sticky until the next START from HALT.
REQ-018 INSTR_CNT  output  CNT_W  retired-instruction count.

Function
REQ-019 States SHALL be IDLE, P1, P2, P3, P4, P5, HALT, and PAUSE (PAUSE only with STEP_MODE_EN); all outputs SHALL decode from registered state (Moore).
REQ-020 IDLE: START=1 -> P1 on the next edge; otherwise remain in IDLE.
REQ-021 P1: IR_LOAD=1 and PC_INC=1 for exactly this cycle; next state P2.
REQ-022 P2: latch MEM_ACCESS into an internal flag; HALT_CMD=1 -> HALT, else -> P3; HALT_CMD has priority over MEM_ACCESS.
REQ-023 P3: execute cycle with no strobes; next state P4.
REQ-024 P4, flag=0: leave after one cycle -> P5, MEM_EN=0.
REQ-025 P4, flag=1, normal access: MEM_EN=1 every P4 cycle; MEM_READY=1 -> P5 on the next edge.
REQ-026 P4, flag=1, wait counting: wait counter clears on entry to P4 and increments each cycle with MEM_READY=0.
REQ-027 P4, flag=1, timeout: counter reaching MEM_WAIT_MAX with MEM_READY=0 -> HALT with ERR set; MEM_READY in that same cycle wins (-> P5, no ERR).
REQ-028 P5: REG_WE_EN=1 for exactly this cycle; INSTR_CNT increments, saturating at all-ones; next state P1 (or PAUSE per REQ-036).
REQ-029 HALT: HALTED=1, RUNNING=0, PHASE=0; START=1 -> P1 and clears ERR; INSTR_CNT is retained.
REQ-030 START in P1..P5 or PAUSE SHALL be ignored; MEM_READY outside P4 SHALL be ignored.
REQ-031 Latency: START sampled at edge k gives P1 in cycle k+1; a non-memory instruction occupies 5 cycles; a memory instruction occupies 5+w cycles (w = wait cycles).

Reset
REQ-032 rst=1 SHALL force IDLE immediately, regardless of clk, including mid-instruction or mid-wait.
REQ-033 Reset values: PHASE=0, IR_LOAD=0, PC_INC=0, MEM_EN=0, REG_WE_EN=0, RUNNING=0, HALTED=0, ERR=0, INSTR_CNT=0, wait counter=0, memory flag=0.
REQ-034 After rst deasserts, the sequencer SHALL leave IDLE only via START.

Configuration
REQ-035 Macro STEP_MODE_EN SHALL compile in single-step support: the STEP port and the PAUSE state.
REQ-036 With STEP_MODE_EN defined: P5 -> PAUSE; in PAUSE, RUNNING=1 and PHASE=0; STEP=1 -> P1 on the next edge.
REQ-037 Without STEP_MODE_EN: no STEP port and no PAUSE state; P5 -> P1 directly.

Verification
REQ-038 Reset, START=1 for one cycle, HALT_CMD=0, MEM_ACCESS=0 -> PHASE sequence 00001, 00010, 00100, 01000, 10000, 00001; INSTR_CNT=1 after the first P5.
REQ-039 MEM_ACCESS=1 in P2, MEM_READY asserted on the 3rd P4 cycle -> MEM_EN=1 for 3 cycles, then P5; ERR=0.
REQ-040 MEM_ACCESS=1, MEM_READY held 0, MEM_WAIT_MAX=8 -> HALT with ERR=1, HALTED=1, INSTR_CNT unchanged; START -> P1 and ERR=0.
REQ-041 HALT_CMD=1 and MEM_ACCESS=1 in P2 -> HALT next cycle; REG_WE_EN never asserts for that instruction.
REQ-042 rst asserted asynchronously mid-P4 with MEM_EN=1 -> all outputs at reset values before the next clk edge.
REQ-043 STEP_MODE_EN defined, CNT_W=4: 20 instructions stepped -> PAUSE after each P5; INSTR_CNT saturates at 15.
